// File: rtl/mips_isa_pkg.sv
// MIPS encoding constants and shared enums for the instruction loader and control unit.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4,
    KIND_J     = 3'd5
  } kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational packer: instruction fields to a 32-bit MIPS word plus a legality flag.
module mips_instr_encode
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  alu_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  logic [5:0] funct;

  always_comb begin
    funct = '0;
    legal = 1'b1;
    word  = '0;
    case (kind_e'(kind))
      KIND_RTYPE: begin
        case (alu_sel_e'(alu_sel))
          ALU_ADD: funct = FUNCT_ADD;
          ALU_SUB: funct = FUNCT_SUB;
          ALU_AND: funct = FUNCT_AND;
          ALU_OR:  funct = FUNCT_OR;
          ALU_SLT: funct = FUNCT_SLT;
          default: legal = 1'b0;
        endcase
        word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      end
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams encoded MIPS words into consecutive instruction-memory addresses.
// Optional LOADER_CHECKSUM_EN adds a running XOR of all words written this session.
//
//   state   | meaning
//   ST_IDLE | after reset, waiting for start
//   ST_LOAD | accepting fields, writing one word per legal handshake
//   ST_DONE | session complete (full or finished), waiting for start
module instr_mem_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        alu_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done,
  output logic              err_illegal
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_e      state, state_nxt;
  logic [31:0] word;
  logic        legal;
  logic        fire;
  logic        wr;
  logic        restart;

  mips_instr_encode u_encode (
    .kind    (kind),
    .alu_sel (alu_sel),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .imm     (imm),
    .target  (target),
    .word    (word),
    .legal   (legal)
  );

  assign fire    = in_valid & in_ready;
  assign wr      = fire & legal;
  assign restart = start & (state != ST_LOAD);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        // a coincident legal handshake is still written on the finishing edge
        if (finish || (wr && (words_loaded == LAST_IDX))) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      err_illegal  <= 1'b0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr    <= BASE + words_loaded[ADDR_W-1:0];
        imem_wdata   <= word;
        words_loaded <= words_loaded + 1'b1;
      end
      if (fire && !legal) err_illegal <= 1'b1;
      if (restart) begin
        words_loaded <= '0;
        err_illegal  <= 1'b0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       checksum <= '0;
    else if (restart) checksum <= '0;
    else if (wr)      checksum <= checksum ^ word;
  end
`endif

endmodule
